// File: rtl/qcl_word_gather.sv
// Packs narrow elements into wide words, lane 0 first, and presents each closed
// word with its valid-lane count. One word can be held in the accumulator while the output is busy.
`ifndef BSG_WIDTH
`define BSG_WIDTH(x) ($clog2((x)+1))
`endif

module qcl_word_gather #(
  parameter int elem_width_p = 1,
  parameter int els_p        = 1
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            v_i,
  input  logic [elem_width_p-1:0]         data_i,
  input  logic                            last_i,
  output logic                            ready_o,
  output logic                            v_o,
  output logic [els_p*elem_width_p-1:0]   data_o,
  output logic [`BSG_WIDTH(els_p)-1:0]    count_o,
  input  logic                            yumi_i
);

  localparam int cnt_w_lp  = `BSG_WIDTH(els_p);
  localparam int word_w_lp = els_p * elem_width_p;

  logic [word_w_lp-1:0] acc_q, acc_d, data_q, data_d, merged;
  logic [cnt_w_lp-1:0]  cnt_q, cnt_d, count_q, count_d, closed_cnt;
  logic                 done_q, done_d, v_q, v_d;
  logic                 accept, close, out_free, drain;

  // ready comes straight from state; reset only gates it off
  assign ready_o    = reset_n_i & ~done_q;
  assign accept     = v_i & ready_o;
  assign closed_cnt = cnt_q + cnt_w_lp'(1);
  assign close      = accept & (last_i | (cnt_q == cnt_w_lp'(els_p - 1)));
  assign out_free   = ~v_q | yumi_i;
  assign drain      = done_q & out_free;

  // Lanes above cnt_q are always zero in acc_q, so the merge also zero-fills them.
  always_comb begin
    merged = acc_q;
    for (int k = 0; k < els_p; k++) begin
      if (cnt_q == cnt_w_lp'(k)) merged[k*elem_width_p +: elem_width_p] = data_i;
    end
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    v_d     = v_q;
    data_d  = data_q;
    count_d = count_q;
    if (drain) begin
      v_d     = 1'b1;
      data_d  = acc_q;
      count_d = cnt_q;
      acc_d   = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else if (close && out_free) begin
      v_d     = 1'b1;
      data_d  = merged;
      count_d = closed_cnt;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      if (yumi_i) begin
        v_d     = 1'b0;
        data_d  = '0;
        count_d = '0;
      end
      if (close) begin
        acc_d  = merged;
        cnt_d  = closed_cnt;
        done_d = 1'b1;
      end else if (accept) begin
        acc_d = merged;
        cnt_d = closed_cnt;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      v_q     <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      v_q     <= v_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign v_o     = v_q;
  assign data_o  = data_q;
  assign count_o = count_q;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    assert (els_p >= 1 && elem_width_p >= 1)
      else $error("qcl_word_gather: els_p and elem_width_p must be >= 1");
    if (reset_n_i) begin
      assert (!(yumi_i && !v_q))
        else $error("qcl_word_gather: yumi_i asserted with no valid word");
    end
  end
`endif

endmodule

// File: tb/tb_qcl_word_gather.sv
// Scoreboard bench for qcl_word_gather: a 4-lane instance under directed and random
// traffic, plus a 1-lane instance for the degenerate width.
module tb_qcl_word_gather;
  localparam int W  = 8;
  localparam int E  = 4;
  localparam int CW = $clog2(E + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n = 1'b0;
  logic           v_i = 1'b0, last_i = 1'b0, yumi_i = 1'b0;
  logic [W-1:0]   data_i = '0;
  logic           ready_o, v_o;
  logic [E*W-1:0] data_o;
  logic [CW-1:0]  count_o;

  logic           v1_i = 1'b0, yumi1_i = 1'b0;
  logic [W-1:0]   data1_i = '0;
  logic           ready1_o, v1_o;
  logic [W-1:0]   data1_o;
  logic [0:0]     count1_o;

  qcl_word_gather #(.elem_width_p(W), .els_p(E)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .data_i(data_i), .last_i(last_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .count_o(count_o), .yumi_i(yumi_i));

  qcl_word_gather #(.elem_width_p(W), .els_p(1)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v1_i), .data_i(data1_i), .last_i(1'b0),
    .ready_o(ready1_o), .v_o(v1_o), .data_o(data1_o), .count_o(count1_o), .yumi_i(yumi1_i));

  int tests = 0, fails = 0;
  int ymode = 1;  // 0: never pop, 1: pop whenever valid, 2: random pops
  int n1_popped = 0;

  typedef struct { logic [E*W-1:0] d; int c; } word_t;
  word_t      expq[$];
  logic [W-1:0] pend[$];
  logic [W-1:0] q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Consumer: decided shortly after the falling edge, only when a word is shown.
  initial forever begin
    @(negedge clk);
    #1;
    case (ymode)
      0:       yumi_i = 1'b0;
      1:       yumi_i = v_o;
      default: yumi_i = v_o & ($urandom_range(0, 1) == 1);
    endcase
    yumi1_i = v1_o;
  end

  // Monitor / reference model for the 4-lane instance.
  initial begin
    word_t w;
    bit exp_v = 0, held = 0, exp_drain = 0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        pend.delete();
        expq.delete();
        exp_v = 0; held = 0; exp_drain = 0;
        continue;
      end
      if (exp_v) chk("close_latency_v", v_o, 1);
      if (exp_drain) begin
        chk("drain_v", v_o, 1);
        chk("drain_ready", ready_o, 1);
      end
      exp_v = 0; exp_drain = 0;
      if (held) chk("held_ready_low", ready_o, 0);
      if (!v_o) begin
        chk("idle_data", data_o, 0);
        chk("idle_count", count_o, 0);
      end
      if (v_o && yumi_i) begin
        if (expq.size() == 0) fail_now("unexpected_word");
        else begin
          w = expq.pop_front();
          chk("word_data", data_o, w.d);
          chk("word_count", count_o, w.c);
        end
        if (held) begin held = 0; exp_drain = 1; end
      end
      if (v_i && ready_o) begin
        pend.push_back(data_i);
        if (last_i || pend.size() == E) begin
          w.d = '0;
          for (int i = 0; i < pend.size(); i++) w.d[i*W +: W] = pend[i];
          w.c = pend.size();
          expq.push_back(w);
          pend.delete();
          if (!v_o || yumi_i) exp_v = 1;
          else held = 1;
        end
      end
    end
  end

  // Monitor for the 1-lane instance: every accepted element is its own word.
  initial forever begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      q1.delete();
      continue;
    end
    if (!v1_o) chk("deg_idle_count", count1_o, 0);
    if (v1_o && yumi1_i) begin
      n1_popped++;
      if (q1.size() == 0) fail_now("deg_unexpected_word");
      else begin
        chk("deg_data", data1_o, q1.pop_front());
        chk("deg_count", count1_o, 1);
      end
    end
    if (v1_i && ready1_o) q1.push_back(data1_i);
  end

  task automatic send(input logic [W-1:0] d, input logic l);
    bit got = 0;
    v_i = 1'b1; data_i = d; last_i = l;
    for (int b = 0; b < 200 && !got; b++) begin
      #2;
      got = ready_o;
      @(negedge clk);
    end
    if (!got) fail_now("send_timeout");
  endtask

  task automatic idle(input int n);
    v_i = 1'b0; last_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2;
    chk("ready_in_reset", ready_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("rst_v", v_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_ready1", ready1_o, 1);
    @(negedge clk);

    // full words
    ymode = 1;
    for (int i = 0; i < 8; i++) send(W'(8'h10 + i), 1'b0);
    idle(3);
    // partial word, then single-element last
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    send(8'h5C, 1'b1);
    idle(3);

    // backpressure
    ymode = 0;
    for (int i = 0; i < 8; i++) send(W'(8'h20 + i), 1'b0);
    #2;
    chk("bp_ready_low", ready_o, 0);
    v_i = 1'b1; data_i = 8'h28; last_i = 1'b0;
    repeat (3) @(negedge clk);
    ymode = 1;
    @(negedge clk);
    #2;
    chk("bp_word2_v", v_o, 1);
    chk("bp_ready_back", ready_o, 1);
    chk("bp_word2_count", count_o, 4);
    @(negedge clk);
    for (int i = 8; i < 12; i++) send(W'(8'h20 + i), 1'b0);
    idle(4);

    // reset mid-word
    for (int i = 0; i < 3; i++) send(W'(8'h30 + i), 1'b0);
    v_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("midrst_v", v_o, 0);
    chk("midrst_count", count_o, 0);
    chk("midrst_ready", ready_o, 1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(W'(8'h40 + i), 1'b0);
    idle(3);

    // degenerate width, full rate
    n1_popped = 0;
    for (int i = 0; i < 3; i++) begin
      v1_i = 1'b1; data1_i = W'(8'h61 + i);
      #2;
      chk("deg_ready_full_rate", ready1_o, 1);
      @(negedge clk);
    end
    v1_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("deg_word_total", n1_popped, 3);

    // randomized traffic
    ymode = 2;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(W'($urandom), ($urandom_range(0, 3) == 0));
    end
    send(8'hEE, 1'b1);
    idle(0);
    ymode = 1;
    for (int b = 0; b < 200 && expq.size() != 0; b++) @(negedge clk);
    if (expq.size() != 0) fail_now("drain_timeout");
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
